// File: rtl/uart_rx_fifo_if.sv
// Byte-stream interface between the UART receiver, the receive FIFO and its consumer.
// The slave modport is the FIFO; the master modport is the receiver/consumer side.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [7:0]      dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [ADDR_W:0] count;
  logic            full;
  logic            overflow;
  logic            ovf_clr;

  modport slave (
    input  rx_data, rx_valid, dout_ready, ovf_clr,
    output dout, dout_valid, count, full, overflow
  );

  modport master (
    output rx_data, rx_valid, dout_ready, ovf_clr,
    input  dout, dout_valid, count, full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: one push per rising edge of rx_valid,
// first-word-fall-through output with ready/valid handshake and sticky overflow.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              rx_valid_q;
  logic              overflow;

  logic push;
  logic pop;
  logic is_full;
  logic do_write;
  logic drop;

  // rx_valid_q resets high so a valid level still asserted out of reset is not a new byte.
  assign push     = bus.rx_valid & ~rx_valid_q;
  assign pop      = (count != '0) & bus.dout_ready;
  assign is_full  = (count == DEPTH_CNT);
  assign do_write = push & (~is_full | pop);
  assign drop     = push & is_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      rx_valid_q <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in this
      // block sees the pre-edge value regardless of statement order.
      rx_valid_q <= bus.rx_valid;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)             overflow <= 1'b1;
      else if (bus.ovf_clr) overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through rd_ptr/count, which are reset, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.dout_valid = (count != '0);
  assign bus.dout       = bus.dout_valid ? mem[rd_ptr] : 8'h00;
  assign bus.count      = count;
  assign bus.full       = is_full;
  assign bus.overflow   = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table vectors, directed corner sequences
// and random traffic compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a byte queue plus the previous valid level and the sticky flag.
  logic [7:0] m_q[$];
  bit         m_prev;
  bit         m_ovf;

  typedef struct {
    bit         rv;
    logic [7:0] data;
    bit         rdy;
    bit         clr;
    int         exp_count;
    bit         exp_dv;
    logic [7:0] exp_dout;
    bit         exp_full;
    bit         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rv, input logic [7:0] d, input bit rdy,
                              input bit clr, input bit r);
    bit push, pop, room;
    if (r) begin
      m_q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
    end else begin
      push = rv && !m_prev;
      pop  = (m_q.size() > 0) && rdy;
      room = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (push && room) m_q.push_back(d);
      if (push && !room) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
      m_prev = rv;
    end
  endtask

  task automatic check_model();
    check("model_count", 32'(bus.count), 32'(m_q.size()));
    check("model_dout_valid", 32'(bus.dout_valid), 32'(m_q.size() != 0));
    check("model_dout", 32'(bus.dout), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    check("model_full", 32'(bus.full), 32'(m_q.size() == DEPTH));
    check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  // Drives one cycle of inputs, advances the model at the edge, checks #1 later.
  task automatic step(input bit rv, input logic [7:0] d, input bit rdy,
                      input bit clr, input bit r);
    bus.rx_valid   = rv;
    bus.rx_data    = d;
    bus.dout_ready = rdy;
    bus.ovf_clr    = clr;
    rst            = r;
    @(posedge clk);
    model_update(rv, d, rdy, clr, r);
    #1;
    check_model();
  endtask

  // A one-cycle pulse followed by one low cycle: exactly one push.
  task automatic pulse(input logic [7:0] d, input bit rdy);
    step(1'b1, d, rdy, 1'b0, 1'b0);
    step(1'b0, d, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain_expect(input string name, input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      check(name, 32'(bus.dout), 32'(first + 8'(i)));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  vec_t vecs[8];
  logic [7:0] got[$];

  initial begin
    bus.rx_valid   = 1'b1;
    bus.rx_data    = 8'h00;
    bus.dout_ready = 1'b0;
    bus.ovf_clr    = 1'b0;
    rst            = 1'b1;
    m_prev         = 1'b1;
    m_ovf          = 1'b0;

    // 1: valid held high through and after reset never pushes
    for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("reset_dout", 32'(bus.dout), 32'h00);

    // Table vectors starting from the empty FIFO with valid high
    vecs[0] = '{rv:0, data:8'h00, rdy:0, clr:0, exp_count:0, exp_dv:0, exp_dout:8'h00, exp_full:0, exp_ovf:0};
    vecs[1] = '{rv:1, data:8'h11, rdy:1, clr:0, exp_count:1, exp_dv:1, exp_dout:8'h11, exp_full:0, exp_ovf:0};
    vecs[2] = '{rv:1, data:8'h11, rdy:0, clr:0, exp_count:1, exp_dv:1, exp_dout:8'h11, exp_full:0, exp_ovf:0};
    vecs[3] = '{rv:0, data:8'h22, rdy:0, clr:0, exp_count:1, exp_dv:1, exp_dout:8'h11, exp_full:0, exp_ovf:0};
    vecs[4] = '{rv:1, data:8'h22, rdy:1, clr:0, exp_count:1, exp_dv:1, exp_dout:8'h22, exp_full:0, exp_ovf:0};
    vecs[5] = '{rv:0, data:8'h00, rdy:1, clr:0, exp_count:0, exp_dv:0, exp_dout:8'h00, exp_full:0, exp_ovf:0};
    vecs[6] = '{rv:0, data:8'h00, rdy:1, clr:0, exp_count:0, exp_dv:0, exp_dout:8'h00, exp_full:0, exp_ovf:0};
    vecs[7] = '{rv:0, data:8'h00, rdy:0, clr:1, exp_count:0, exp_dv:0, exp_dout:8'h00, exp_full:0, exp_ovf:0};
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rv, vecs[i].data, vecs[i].rdy, vecs[i].clr, 1'b0);
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_dv", i), 32'(bus.dout_valid), 32'(vecs[i].exp_dv));
      check($sformatf("vec%0d_dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
    end

    // 2: three pulses, then drain in order
    pulse(8'h41, 1'b0);
    pulse(8'h42, 1'b0);
    pulse(8'h43, 1'b0);
    check("three_count", 32'(bus.count), 32'd3);
    check("three_head", 32'(bus.dout), 32'h41);
    drain_expect("three_drain", 3, 8'h41);
    check("three_empty_count", 32'(bus.count), 32'd0);
    check("three_empty_dv", 32'(bus.dout_valid), 32'd0);

    // 3: long valid level yields one push
    for (int i = 0; i < 1000; i++) step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("level_count", 32'(bus.count), 32'd1);
    check("level_dout", 32'(bus.dout), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 4: overfill, drop with simultaneous clear, drain, clear
    for (int i = 0; i <= 16; i++) pulse(8'(i), 1'b0);
    check("ovf_full", 32'(bus.full), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    check("drop_beats_clr", 32'(bus.overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drain_expect("ovf_drain", 16, 8'h00);
    check("ovf_drained", 32'(bus.count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);

    // 5: push into a full FIFO with a same-cycle pop
    for (int i = 0; i < 16; i++) pulse(8'h80 + 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("fullpp_count", 32'(bus.count), 32'd16);
    check("fullpp_ovf", 32'(bus.overflow), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drain_expect("fullpp_drain", 15, 8'h81);
    check("fullpp_last", 32'(bus.dout), 32'hAA);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 6: 40 bytes with random ready, pointers wrap twice
    got.delete();
    for (int i = 0; i < 40; i++) begin
      for (int ph = 0; ph < 3; ph++) begin
        bit rdy;
        rdy = ($urandom_range(3, 0) != 0);
        if (bus.dout_valid && rdy) got.push_back(bus.dout);
        step(ph == 0, 8'(i), rdy, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 40 && bus.dout_valid; i++) begin
      got.push_back(bus.dout);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    check("wrap_total", 32'(got.size()), 32'd40);
    for (int i = 0; i < got.size(); i++) check("wrap_order", 32'(got[i]), 32'(i));
    check("wrap_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 5; i++) pulse(8'hC0 + 8'(i), 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd5);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_dv", 32'(bus.dout_valid), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("post_rst_nopush", 32'(bus.count), 32'd0);

    // Random traffic against the model; first fill-biased, then drain-biased
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      rdy = (i < 300) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      step(1'($urandom_range(1, 0)), 8'($urandom), rdy,
           ($urandom_range(15, 0) == 0), ($urandom_range(249, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
